debouncer: RTL and testbench
============================

DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 65000, defining the consecutive cycles a new level must persist before it is accepted; legal range 1..65535.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port btn_in, input, 1 bit: raw, asynchronous, bouncing button level (1 = pressed).
REQ-005 The module SHALL have port btn_state, output, 1 bit: registered debounced button level.
REQ-006 The module SHALL have port btn_pressed, output, 1 bit: registered one-cycle pulse on each accepted press.

Function
REQ-007 btn_in SHALL pass through a 2-flop synchronizer (sync1 <= btn_in, sync2 <= sync1) before any other use.
REQ-008 The module SHALL keep a 16-bit stability counter cnt.
REQ-009 On each edge with sync2 == btn_state, cnt SHALL clear to 0 and btn_state SHALL hold.
REQ-010 On each edge with sync2 != btn_state and cnt < STABLE_CYCLES-1, cnt SHALL increment by 1.
REQ-011 On each edge with sync2 != btn_state and cnt == STABLE_CYCLES-1, btn_state SHALL load sync2 and cnt SHALL clear to 0.
REQ-012 btn_pressed SHALL be 1 for exactly the cycle after the edge at which btn_state goes 0->1; otherwise 0.
REQ-013 A btn_state 1->0 transition SHALL NOT assert btn_pressed.
REQ-014 Latency: a clean btn_in change sampled at edge N SHALL update btn_state at edge N+1+STABLE_CYCLES; for default, btn_pressed is high from edge 65001 to edge 65002 after the first sampling edge.
REQ-015 Any single mismatch-free cycle (bounce back) before acceptance SHALL restart the count from 0; no partial credit.
REQ-016 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-017 A held level SHALL produce at most one btn_pressed pulse; re-arming requires an accepted release then an accepted press.
REQ-018 No combinational path SHALL exist from btn_in to any output.

Reset
REQ-019 While reset == 0, sync1, sync2, btn_state, btn_pressed and cnt SHALL be 0 immediately, independent of clk.
REQ-020 After reset deasserts, operation SHALL resume at the next rising edge; btn_in already high at release SHALL be accepted as a press after the normal latency.
REQ-021 Reset asserted mid-count SHALL discard the count and any pending pulse.

Verification
REQ-022 reset=1, btn_in 0->1 at t=1 ns, held 65536 cycles (1 ns clk) -> exactly one btn_pressed pulse, 1 cycle wide, ~65002 cycles after the edge; btn_state=1 afterward.
REQ-023 btn_in pulses high for 100 cycles, repeated 10 times with 100-cycle gaps -> btn_pressed stays 0; btn_state stays 0.
REQ-024 Pressed, accepted, then released and held low STABLE_CYCLES+5 cycles -> btn_state returns to 0; no btn_pressed pulse on release.
REQ-025 STABLE_CYCLES=4, btn_in=1 with reset pulled low after 3 cycles -> all outputs 0 at once; after release, press accepted 5 edges later.
REQ-026 STABLE_CYCLES=4, btn_in=1 for 3 cycles, 0 for 1 cycle, then 1 -> acceptance 5 edges after the final rise, not earlier.

Source files
------------

// File: rtl/debouncer.sv
// Button debouncer: 2-flop synchronizer followed by a stability counter.
// btn_state follows the synchronized input only after it has differed for STABLE_CYCLES edges.
module debouncer #(
  parameter int unsigned STABLE_CYCLES = 65000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_state,
  output logic btn_pressed
);

  localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        state_q, state_d;
  logic        pressed_q, pressed_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = btn_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = 1'b0;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      // Compare with >= so the counter can never run past the limit.
      state_d   = sync2_q;
      cnt_d     = '0;
      pressed_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= 1'b0;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_state   = state_q;
  assign btn_pressed = pressed_q;

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer: a run-length model of the raw input predicts
// each cycle's outputs; a monitor compares them on the falling edge.
module tb_debouncer;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic btn_state, btn_pressed;

  debouncer #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_state(btn_state), .btn_pressed(btn_pressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st;
    logic pr;
  } exp_t;

  exp_t expq[$];
  bit   hist[$];
  bit   mdl_state;
  bit   running = 1'b0;
  int   checks = 0, errors = 0;
  int   edge_n = 0, first_press = -1, press_cnt = 0;

  task automatic check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The synchronizer holds zeros after reset, so history starts as zeros.
  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
    mdl_state = 1'b0;
  endfunction

  // Reference: the level flips when the S raw samples taken two to S+1 edges
  // ago all disagree with the current debounced level.
  always @(posedge clk) begin
    if (running && reset) begin
      bit   all_diff;
      exp_t e;
      edge_n++;
      hist.push_back(btn_in);
      if (hist.size() > S + 2) void'(hist.pop_front());
      all_diff = 1'b1;
      for (int i = 0; i < S; i++)
        if (hist[i] == mdl_state) all_diff = 1'b0;
      e.pr = all_diff && !mdl_state;
      if (all_diff) mdl_state = !mdl_state;
      e.st = mdl_state;
      expq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check_bit("btn_state", btn_state, e.st);
      check_bit("btn_pressed", btn_pressed, e.pr);
      if (btn_pressed === 1'b1) begin
        press_cnt++;
        if (first_press < 0) first_press = edge_n;
      end
    end
  end

  task automatic hold(bit v, int n);
    btn_in = v;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic mark();
    edge_n = 0;
    first_press = -1;
    press_cnt = 0;
  endtask

  task automatic release_reset();
    model_reset();
    mark();
    reset = 1'b1;
    running = 1'b1;
  endtask

  task automatic assert_reset(string name);
    running = 1'b0;
    reset = 1'b0;
    expq.delete();
    #1;
    check_bit({name, "_state"}, btn_state, 1'b0);
    check_bit({name, "_pressed"}, btn_pressed, 1'b0);
  endtask

  initial begin
    #1;
    check_bit("rst_state", btn_state, 1'b0);
    check_bit("rst_pressed", btn_pressed, 1'b0);
    btn_in = 1'b1;
    @(negedge clk);
    #1;
    hold(1'b1, 2);

    // Input already high when reset releases.
    release_reset();
    hold(1'b1, 12);
    check_int("press_after_release_edge", first_press, S + 2);
    check_int("press_after_release_count", press_cnt, 1);

    // Release accepted without a pulse, then reset mid-count.
    mark();
    hold(1'b0, S + 6);
    check_int("release_no_pulse", press_cnt, 0);
    hold(1'b1, S + 6);
    check_int("repress_count", press_cnt, 1);
    assert_reset("rst_high");
    hold(1'b0, S + 4);
    release_reset();
    hold(1'b1, 3);
    assert_reset("rst_midcount");
    hold(1'b1, 2);
    release_reset();
    hold(1'b1, 12);
    check_int("press_after_midcount_rst", first_press, S + 2);

    // Single-cycle bounce restarts the count.
    hold(1'b0, S + 6);
    hold(1'b1, S - 1);
    hold(1'b0, 1);
    mark();
    hold(1'b1, 12);
    check_int("bounce_restart_edge", first_press, S + 2);
    check_int("bounce_restart_count", press_cnt, 1);

    // Short glitches never get accepted.
    hold(1'b0, S + 6);
    mark();
    for (int k = 0; k < 10; k++) begin
      hold(1'b1, S - 1);
      hold(1'b0, S - 1);
    end
    check_int("glitch_no_press", press_cnt, 0);
    check_bit("glitch_state", btn_state, 1'b0);

    // Random runs of both short and long lengths, with one reset in between.
    for (int r = 0; r < 300; r++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 2 * S + 2));
      if (r == 150) begin
        running = 1'b0;
        reset = 1'b0;
        expq.delete();
        hold(1'($urandom_range(0, 1)), 2);
        release_reset();
      end
    end
    hold(1'b0, 3);
    check_int("queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
